uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between up to eight byte producers (counters, status reporters, debug taps). The transmitter has only a one-cycle `transmit` strobe and no busy/done feedback, so this block times each frame itself from baud parameters and never strobes the transmitter before the previous frame has finished. It sits in the top level between the producers and the `uart` instance, replacing direct `send`/`data` wiring.

---
 rtl/uart_tx_sched_pkg.sv | 19 +
 rtl/uart_tx_sched_rr_pick.sv | 41 ++++
 rtl/uart_tx_sched.sv | 125 ++++++++++++
 tb/tb_uart_tx_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t          : scheduler FSM states (IDLE, LAUNCH, WAIT)
//   CLKS_PER_BIT_9600_50M  : clk cycles per bit for 9600 baud at 50 MHz
//   UART_FRAME_BITS        : start + 8 data + stop
// ---------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } sched_state_t;

  localparam int CLKS_PER_BIT_9600_50M = 5208;
  localparam int UART_FRAME_BITS       = 10;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches upward from ptr+1 (modulo
// NUM_REQ) and returns the first requester whose req bit is set.
//   req    in  NUM_REQ : request vector
//   ptr    in  3       : index of the previous winner
//   winner out 3       : selected index (equals ptr when no request)
//   any    out 1       : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         winner,
  output logic               any
);

  // Index reached by stepping 'step' places above 'base', wrapped once.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return 3'(sum);
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it holding its old value (no latch).
  always_comb begin
    winner = ptr;
    any    = |req;
    // Walk from the farthest candidate to the nearest so the nearest set
    // bit after ptr is the last assignment and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (3'(i) == wrap_idx(ptr, k))) winner = 3'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter between up to eight
// byte producers. The UART has no busy feedback, so each frame is timed
// locally from the baud parameters before the next strobe is allowed.
//   clk          in  1          : system clock
//   rst_n        in  1          : asynchronous active-low reset
//   req          in  NUM_REQ    : per-requester request, held until ack
//   data_in      in  8*NUM_REQ  : byte of requester i on [8i+7:8i]
//   ack          out NUM_REQ    : one-hot, one-cycle capture pulse
//   grant_id     out 3          : index of the last granted requester
//   tx_transmit  out 1          : one-cycle strobe to the UART
//   tx_data      out 8          : byte to the UART, stable between acks
//   busy         out 1          : frame launching or in flight
// ---------------------------------------------------------------------------
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_9600_50M,
  parameter int BITS_PER_FRAME = UART_FRAME_BITS,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 tx_transmit,
  output logic [7:0]           tx_data,
  output logic                 busy
);

  localparam int FRAME_CYCLES = CLKS_PER_BIT * BITS_PER_FRAME;
  localparam int WAIT_LEN     = FRAME_CYCLES + GAP_CYCLES;
  localparam int CNT_W        = $clog2(WAIT_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       PTR_RST  = 3'(NUM_REQ - 1);

  sched_state_t         state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           ptr;
  logic [2:0]           pick_id;
  logic                 pick_any;
  logic                 grant_en;
  logic                 launch;
  logic [NUM_REQ-1:0]   ack_next;
  logic [7:0]           data_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .any    (pick_any)
  );

  // One-hot ack and byte mux for the current pick.
  always_comb begin
    ack_next = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == pick_id) begin
        ack_next[i] = 1'b1;
        data_sel    = data_in[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any)   state_next = LAUNCH;
      LAUNCH:                  state_next = WAIT;
      WAIT:    if (cnt == '0)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // req only matters in IDLE; WAIT ignores it entirely.
  always_comb begin
    grant_en = (state == IDLE) && pick_any;
    launch   = (state == LAUNCH);
    busy     = (state != IDLE);
  end

  // Grant capture, strobe and frame timer. The strobe is registered off
  // LAUNCH so it trails the ack by one cycle and tx_data is already settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack         <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      tx_transmit <= 1'b0;
      ptr         <= PTR_RST;
      cnt         <= '0;
    end else begin
      ack         <= '0;
      tx_transmit <= launch;
      if (grant_en) begin
        ack      <= ack_next;
        grant_id <= pick_id;
        tx_data  <= data_sel;
        ptr      <= pick_id;
      end
      if (launch) begin
        cnt <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Scoreboard bench for uart_tx_sched. A transaction-level model predicts each
// grant from the round-robin rule and the frame period; a monitor compares
// the DUT's ack / strobe / busy behaviour against those predictions.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int NUM_REQ        = 4;
  localparam int CLKS_PER_BIT   = 4;
  localparam int BITS_PER_FRAME = 10;
  localparam int GAP_CYCLES     = 0;
  localparam int WAIT_LEN       = CLKS_PER_BIT * BITS_PER_FRAME + GAP_CYCLES;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] data_in = '0;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           grant_id;
  logic                 tx_transmit;
  logic [7:0]           tx_data;
  logic                 busy;

  uart_tx_sched #(
    .NUM_REQ        (NUM_REQ),
    .CLKS_PER_BIT   (CLKS_PER_BIT),
    .BITS_PER_FRAME (BITS_PER_FRAME),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .grant_id    (grant_id),
    .tx_transmit (tx_transmit),
    .tx_data     (tx_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: one grant per frame period, round-robin from the last
  // winner. Grant at edge t => ack seen in cycle t, strobe in t+1, busy over
  // t..t+WAIT_LEN, next arbitration possible at t+WAIT_LEN+2.
  // ------------------------------------------------------------------------
  typedef struct {
    int         ack_cyc;
    int         id;
    logic [7:0] data;
  } grant_t;

  grant_t sb_q[$];
  int cyc      = 0;
  int m_ptr    = NUM_REQ - 1;
  int next_arb = 0;
  int last_arb = -1000;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ptr    = NUM_REQ - 1;
      next_arb = 0;
      last_arb = -1000;
      sb_q.delete();
    end else if (cyc >= next_arb && req != '0) begin
      grant_t g;
      int     win;
      win = m_ptr;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (req[idx]) begin
          win = idx;
          break;
        end
      end
      g.ack_cyc = cyc;
      g.id      = win;
      g.data    = data_in[8*win +: 8];
      sb_q.push_back(g);
      m_ptr    = win;
      last_arb = cyc;
      next_arb = cyc + WAIT_LEN + 2;
    end
  end

  // ------------------------------------------------------------------------
  // Monitor: samples on the falling edge.
  // ------------------------------------------------------------------------
  int         strobe_due = -1;
  logic [7:0] strobe_data = '0;
  int         obs_ids[$];
  int         strobe_cycs[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ack", ack, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_tx_transmit", tx_transmit, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      strobe_due = -1;
    end else begin
      if (ack != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", ack, 0);
        end else begin
          grant_t g;
          g = sb_q.pop_front();
          check("ack_cycle", cyc, g.ack_cyc);
          check("ack_onehot", ack, 32'd1 << g.id);
          check("grant_id", grant_id, g.id);
          check("ack_tx_data", tx_data, g.data);
          strobe_due  = cyc + 1;
          strobe_data = g.data;
        end
        obs_ids.push_back(int'(grant_id));
      end else if (sb_q.size() > 0 && sb_q[0].ack_cyc <= cyc) begin
        check("ack_missing", ack, 32'd1 << sb_q[0].id);
        void'(sb_q.pop_front());
      end

      check("tx_transmit", tx_transmit, (strobe_due == cyc) ? 1 : 0);
      if (tx_transmit) begin
        strobe_cycs.push_back(cyc);
        if (strobe_due == cyc) check("strobe_tx_data", tx_data, strobe_data);
      end

      check("busy", busy, (cyc >= last_arb && cyc <= last_arb + WAIT_LEN) ? 1 : 0);
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    data_in[8*i +: 8] = b;
  endtask

  // Wait for ack of requester i (i < 0: any requester) within 'limit' cycles.
  task automatic wait_ack(input int i, input int limit);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      tick();
      if (i < 0) seen = (ack != '0);
      else       seen = ack[i];
    end
    if (!seen) check("ack_timeout", 0, 1);
  endtask

  int exp_order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 2};

  initial begin
    int n_before;

    // Reset held with random requests: outputs stay zero.
    rst_n = 1'b0;
    for (int n = 0; n < 8; n++) begin
      req     = 4'($urandom);
      data_in = 32'($urandom);
      tick();
    end
    req   = '0;
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request.
    set_byte(0, 8'h41);
    req = 4'b0001;
    wait_ack(0, 10);
    req = '0;
    repeat (WAIT_LEN + 5) tick();

    // Fresh reset so requester 0 is first again, then all four held.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    obs_ids.delete();
    strobe_cycs.delete();
    set_byte(0, 8'h10);
    set_byte(1, 8'h20);
    set_byte(2, 8'h30);
    set_byte(3, 8'h40);
    req = 4'b1111;
    for (int g = 0; g < 7; g++) wait_ack(-1, 3 * WAIT_LEN);
    req = 4'b1100;
    for (int g = 0; g < 2; g++) wait_ack(-1, 3 * WAIT_LEN);
    req = '0;
    repeat (4) tick();
    check("grant_count", obs_ids.size(), 9);
    for (int k = 0; k < 9 && k < obs_ids.size(); k++)
      check($sformatf("grant_order_%0d", k), obs_ids[k], exp_order[k]);
    for (int k = 1; k < strobe_cycs.size(); k++)
      check($sformatf("strobe_spacing_%0d", k), strobe_cycs[k] - strobe_cycs[k-1], WAIT_LEN + 2);
    repeat (WAIT_LEN + 4) tick();

    // Reset mid-WAIT with requester 1 pending.
    set_byte(0, 8'h5a);
    req = 4'b0001;
    wait_ack(0, 3 * WAIT_LEN);
    set_byte(1, 8'h77);
    req = 4'b0010;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_tx_data", tx_data, 0);
    check("async_rst_grant_id", grant_id, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_ack(1, 10);
    req = '0;
    tick();
    if (obs_ids.size() > 0) check("post_reset_grant", obs_ids[obs_ids.size()-1], 1);
    repeat (WAIT_LEN + 4) tick();

    // One-cycle req pulse during WAIT is ignored.
    set_byte(0, 8'h33);
    req = 4'b0001;
    wait_ack(0, 3 * WAIT_LEN);
    req = '0;
    repeat (10) tick();
    n_before = obs_ids.size();
    set_byte(3, 8'h99);
    req = 4'b1000;
    tick();
    req = '0;
    repeat (WAIT_LEN + 10) tick();
    check("pulse_no_ack", obs_ids.size(), n_before);

    // Random requesters obeying the hold-until-ack rule.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          set_byte(i, 8'($urandom));
        end else if (!req[i] && ($urandom_range(0, 7) == 0)) begin
          req[i] = 1'b1;
          set_byte(i, 8'($urandom));
        end
      end
      tick();
    end
    req = '0;
    repeat (WAIT_LEN + 6) tick();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
